// File: rtl/argmax_layer_pkg.sv
// Shared types for the argmax classification head.
// Optional feature macro: ARGMAX_MARGIN_EN (best-minus-second margin output).
package argmax_layer_pkg;

   localparam int unsigned WORD_SIZE_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } argmax_state_t;

   typedef logic signed [WORD_SIZE_DEF-1:0] word_t;

   // Class index width, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/argmax_compare_unit.sv
// Single-element compare/update step shared by every position of the scan.
// Optional feature macro: ARGMAX_MARGIN_EN (tracks second-best value).
module argmax_compare_unit
   import argmax_layer_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
   parameter int unsigned CLASS_BITS = 4
) (
   input  logic signed [WORD_SIZE-1:0]  best_i,
   input  logic        [CLASS_BITS-1:0] best_idx_i,
`ifdef ARGMAX_MARGIN_EN
   input  logic signed [WORD_SIZE-1:0]  second_i,
   output logic signed [WORD_SIZE-1:0]  second_c_o,
`endif
   input  logic signed [WORD_SIZE-1:0]  elem_i,
   input  logic        [CLASS_BITS-1:0] idx_i,
   output logic signed [WORD_SIZE-1:0]  best_c_o,
   output logic        [CLASS_BITS-1:0] best_idx_c_o
);

   // Strict signed compare so ties keep the earlier (lower) index.
   always_comb begin
      best_c_o     = best_i;
      best_idx_c_o = best_idx_i;
`ifdef ARGMAX_MARGIN_EN
      second_c_o   = second_i;
`endif
      if (elem_i > best_i) begin
         best_c_o     = elem_i;
         best_idx_c_o = idx_i;
`ifdef ARGMAX_MARGIN_EN
         second_c_o   = best_i;
      end else if (elem_i > second_i) begin
         second_c_o   = elem_i;
`endif
      end
   end

endmodule

// File: rtl/argmax_layer.sv
// Sequential argmax over a captured logit vector, one element per cycle.
// Optional feature macro: ARGMAX_MARGIN_EN (adds margin_o = best - second, saturated).
module argmax_layer
   import argmax_layer_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
   parameter int unsigned OUTPUT_SIZE = 10,
   parameter int unsigned CLASS_BITS  = clog2_min1(OUTPUT_SIZE)
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] data_i,
   input  logic                             valid_i,
   output logic                             yumi_o,
   output logic [CLASS_BITS-1:0]            class_o,
   output logic [WORD_SIZE-1:0]             score_o,
`ifdef ARGMAX_MARGIN_EN
   output logic [WORD_SIZE-1:0]             margin_o,
`endif
   output logic                             valid_o,
   input  logic                             ready_i
);

   localparam int unsigned VEC_W = OUTPUT_SIZE * WORD_SIZE;

   argmax_state_t                state_q, state_d;
   logic [CLASS_BITS-1:0]        idx_q, idx_d;
   logic [VEC_W-1:0]             vec_q, vec_d;
   logic signed [WORD_SIZE-1:0]  best_q, best_d;
   logic [CLASS_BITS-1:0]        best_idx_q, best_idx_d;
   logic [CLASS_BITS-1:0]        class_q, class_d;
   logic [WORD_SIZE-1:0]         score_q, score_d;
   logic                         valid_q, valid_d;
   logic                         yumi_c;
   logic                         capture_c;
   logic signed [WORD_SIZE-1:0]  elem_c;
   logic signed [WORD_SIZE-1:0]  cmp_best_c;
   logic [CLASS_BITS-1:0]        cmp_idx_c;

`ifdef ARGMAX_MARGIN_EN
   localparam logic signed [WORD_SIZE-1:0] WORD_MIN  = {1'b1, {(WORD_SIZE-1){1'b0}}};
   localparam logic signed [WORD_SIZE-1:0] WORD_MAX  = {1'b0, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [WORD_SIZE:0]   WIDE_MAX  = {2'b00, {(WORD_SIZE-1){1'b1}}};

   logic signed [WORD_SIZE-1:0]  second_q, second_d;
   logic [WORD_SIZE-1:0]         margin_q, margin_d;
   logic signed [WORD_SIZE-1:0]  cmp_second_c;
   logic signed [WORD_SIZE:0]    diff_c;
   logic [WORD_SIZE-1:0]         margin_sat_c;

   // Margin of the final scan step, widened by one bit then clamped.
   always_comb begin
      diff_c       = {cmp_best_c[WORD_SIZE-1], cmp_best_c} - {cmp_second_c[WORD_SIZE-1], cmp_second_c};
      margin_sat_c = diff_c[WORD_SIZE-1:0];
      if (diff_c > WIDE_MAX) begin
         margin_sat_c = WORD_MAX;
      end
   end
`endif

   // Element currently under inspection from the captured vector.
   assign elem_c = vec_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE];

   argmax_compare_unit #(
      .WORD_SIZE  (WORD_SIZE),
      .CLASS_BITS (CLASS_BITS)
   ) u_cmp (
      .best_i       (best_q),
      .best_idx_i   (best_idx_q),
`ifdef ARGMAX_MARGIN_EN
      .second_i     (second_q),
      .second_c_o   (cmp_second_c),
`endif
      .elem_i       (elem_c),
      .idx_i        (idx_q),
      .best_c_o     (cmp_best_c),
      .best_idx_c_o (cmp_idx_c)
   );

   // Next-state and datapath control; capture can happen from IDLE or DONE.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      vec_d      = vec_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      class_d    = class_q;
      score_d    = score_q;
      valid_d    = valid_q;
      yumi_c     = 1'b0;
      capture_c  = 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_d   = second_q;
      margin_d   = margin_q;
`endif
      case (state_q)
         IDLE: begin
            yumi_c    = valid_i;
            capture_c = valid_i;
         end
         SCAN: begin
            idx_d      = idx_q + CLASS_BITS'(1);
            best_d     = cmp_best_c;
            best_idx_d = cmp_idx_c;
`ifdef ARGMAX_MARGIN_EN
            second_d   = cmp_second_c;
`endif
            if (idx_q == CLASS_BITS'(OUTPUT_SIZE - 1)) begin
               state_d = DONE;
               valid_d = 1'b1;
               class_d = cmp_idx_c;
               score_d = cmp_best_c;
`ifdef ARGMAX_MARGIN_EN
               margin_d = margin_sat_c;
`endif
            end
         end
         DONE: begin
            if (ready_i) begin
               if (valid_i) begin
                  yumi_c    = 1'b1;
                  capture_c = 1'b1;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (capture_c) begin
         vec_d      = data_i;
         best_d     = data_i[WORD_SIZE-1:0];
         best_idx_d = '0;
         idx_d      = CLASS_BITS'(1);
`ifdef ARGMAX_MARGIN_EN
         second_d   = WORD_MIN;
`endif
         if (OUTPUT_SIZE == 1) begin
            state_d = DONE;
            valid_d = 1'b1;
            class_d = '0;
            score_d = data_i[WORD_SIZE-1:0];
`ifdef ARGMAX_MARGIN_EN
            margin_d = WORD_MAX;
`endif
         end else begin
            state_d = SCAN;
            valid_d = 1'b0;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         vec_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         class_q    <= '0;
         score_q    <= '0;
         valid_q    <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
         second_q   <= '0;
         margin_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         vec_q      <= vec_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         class_q    <= class_d;
         score_q    <= score_d;
         valid_q    <= valid_d;
`ifdef ARGMAX_MARGIN_EN
         second_q   <= second_d;
         margin_q   <= margin_d;
`endif
      end
   end

   assign yumi_o  = reset_i & yumi_c;
   assign class_o = class_q;
   assign score_o = score_q;
   assign valid_o = valid_q;
`ifdef ARGMAX_MARGIN_EN
   assign margin_o = margin_q;
`endif

endmodule

// File: tb/tb_argmax_layer.sv
// Directed bench for argmax_layer (WORD_SIZE=16, OUTPUT_SIZE=10).
module tb_argmax_layer;

   localparam int unsigned W  = 16;
   localparam int unsigned N  = 10;
   localparam int unsigned CB = 4;

   typedef struct {
      logic [N*W-1:0] data;
      logic [CB-1:0]  cls;
      logic [W-1:0]   score;
      logic [W-1:0]   margin;
   } vec_t;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic [N*W-1:0] data_i;
   logic           valid_i;
   logic           yumi_o;
   logic [CB-1:0]  class_o;
   logic [W-1:0]   score_o;
   logic           valid_o;
   logic           ready_i;
`ifdef ARGMAX_MARGIN_EN
   logic [W-1:0]   margin_o;
`endif

   int checks   = 0;
   int failures = 0;

   argmax_layer #(
      .WORD_SIZE   (W),
      .OUTPUT_SIZE (N)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .yumi_o  (yumi_o),
      .class_o (class_o),
      .score_o (score_o),
`ifdef ARGMAX_MARGIN_EN
      .margin_o(margin_o),
`endif
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [N*W-1:0] mk(input logic [W-1:0] fill, input int i1,
                                         input logic [W-1:0] v1, input int i2,
                                         input logic [W-1:0] v2);
      logic [N*W-1:0] r;
      for (int k = 0; k < int'(N); k++) r[k*W +: W] = fill;
      r[i1*W +: W] = v1;
      r[i2*W +: W] = v2;
      return r;
   endfunction

   // Offer a vector from IDLE, time the result, check it, then drain.
   task automatic run_vec(input string name, input vec_t v);
      int cycles;
      data_i  = v.data;
      valid_i = 1'b1;
      ready_i = 1'b0;
      #1;
      chk({name, "_yumi"}, 32'(yumi_o), 32'd1);
      tick();
      valid_i = 1'b0;
      data_i  = '1;
      cycles  = 1;
      while (!valid_o && cycles < 40) begin
         tick();
         cycles++;
      end
      chk({name, "_latency"}, 32'(cycles), 32'(N));
      chk({name, "_class"}, 32'(class_o), 32'(v.cls));
      chk({name, "_score"}, 32'(score_o), 32'(v.score));
`ifdef ARGMAX_MARGIN_EN
      chk({name, "_margin"}, 32'(margin_o), 32'(v.margin));
`endif
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk({name, "_drain"}, 32'(valid_o), 32'd0);
   endtask

   vec_t tbl[8];
   vec_t v;
   int   cycles;

   initial begin
      tbl[0] = '{mk(16'h0000, 7, 16'h1000, 7, 16'h1000), 4'd7, 16'h1000, 16'h1000};
      tbl[1] = '{mk(16'hFFF0, 3, 16'hFFFF, 3, 16'hFFFF), 4'd3, 16'hFFFF, 16'h000F};
      tbl[2] = '{mk(16'h0000, 2, 16'h0800, 5, 16'h0800), 4'd2, 16'h0800, 16'h0000};
      tbl[3] = '{mk(16'h8000, 0, 16'h8000, 0, 16'h8000), 4'd0, 16'h8000, 16'h0000};
      tbl[4] = '{mk(16'h0000, 0, 16'h7FFF, 0, 16'h7FFF), 4'd0, 16'h7FFF, 16'h7FFF};
      tbl[5] = '{mk(16'h8001, 6, 16'h0000, 6, 16'h0000), 4'd6, 16'h0000, 16'h7FFF};
      tbl[6] = '{mk(16'hFFFB, 1, 16'hFFFF, 1, 16'hFFFF), 4'd1, 16'hFFFF, 16'h0004};
      tbl[7] = '{mk(16'h0000, 2, 16'h2000, 5, 16'h1800), 4'd2, 16'h2000, 16'h0800};

      reset_i = 1'b0;
      valid_i = 1'b1;
      ready_i = 1'b0;
      data_i  = '0;
      #1;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_class", 32'(class_o), 32'd0);
      chk("rst_score", 32'(score_o), 32'd0);
      chk("rst_yumi", 32'(yumi_o), 32'd0);
      valid_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i]);
      end

      // Backpressure: result held while a second vector waits.
      run_vec("bp_pre", tbl[2]);
      data_i  = mk(16'h0000, 7, 16'h1000, 7, 16'h1000);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      data_i  = '0;
      cycles  = 1;
      while (!valid_o && cycles < 40) begin
         tick();
         cycles++;
      end
      chk("bp_first_latency", 32'(cycles), 32'(N));
      data_i  = mk(16'h0000, 1, 16'h0300, 1, 16'h0300);
      valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         chk("bp_hold_yumi", 32'(yumi_o), 32'd0);
         chk("bp_hold_result", {11'd0, valid_o, class_o, score_o}, {11'd0, 1'b1, 4'd7, 16'h1000});
         tick();
      end
      ready_i = 1'b1;
      #1;
      chk("bp_release_yumi", 32'(yumi_o), 32'd1);
      tick();
      ready_i = 1'b0;
      valid_i = 1'b0;
      data_i  = mk(16'h7FFF, 0, 16'h7FFF, 0, 16'h7FFF);
      chk("bp_valid_drop", 32'(valid_o), 32'd0);
      cycles = 1;
      while (!valid_o && cycles < 40) begin
         tick();
         cycles++;
      end
      chk("bp_second_latency", 32'(cycles), 32'(N));
      chk("bp_second_class", 32'(class_o), 32'd1);
      chk("bp_second_score", 32'(score_o), 32'h0300);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("bp_drain", 32'(valid_o), 32'd0);

      // Reset in the middle of a scan discards everything.
      data_i  = mk(16'h0000, 4, 16'h0400, 4, 16'h0400);
      valid_i = 1'b1;
      tick();
      tick();
      tick();
      tick();
      reset_i = 1'b0;
      #1;
      chk("midrst_valid", 32'(valid_o), 32'd0);
      chk("midrst_class", 32'(class_o), 32'd0);
      chk("midrst_score", 32'(score_o), 32'd0);
      chk("midrst_yumi", 32'(yumi_o), 32'd0);
      valid_i = 1'b0;
      tick();
      reset_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("midrst_no_spurious", 32'(valid_o), 32'd0);
      end
      v = '{mk(16'h0000, 9, 16'h0100, 9, 16'h0100), 4'd9, 16'h0100, 16'h0100};
      run_vec("post_rst", v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
